inv_sub_bytes: RTL and testbench
================================

Name: inv_sub_bytes

Overview:
- AES-128 decryption-round InvSubBytes stage: applies the AES inverse S-box independently to each of the 16 bytes of a 128-bit state.
- Registered, single-cycle pipeline stage with a valid strobe, placed between InvShiftRows and AddRoundKey in the inverse cipher datapath.
- Byte order is big-endian on a [0:127] vector: byte k occupies bits [8k : 8k+7], and byte 0 is the MSB byte.

Parameters:
- None. The state width is fixed at 128 bits (16 bytes of 8 bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies `message` for the current cycle.
- message  input  128 [0:127]  input state, 16 bytes.
- out_valid  output  1  qualifies `crypte`.
- crypte  output  128 [0:127]  substituted state, 16 bytes.

Behaviour:
- Transformation: crypte byte k = InvSbox(message byte k), for k = 0..15.
  - InvSbox is the standard FIPS-197 inverse S-box (256-entry constant table, 8-bit in, 8-bit out).
  - All 16 lookups happen in parallel. There is no cross-byte interaction.
  - Implemented as one combinational lookup function or ROM, instantiated 16 times. No multiplicative-inverse computation.
- Latency: exactly 1 clock.
  - On each rising edge where in_valid = 1: crypte <= InvSbox applied to `message`, and out_valid <= 1.
  - On an edge where in_valid = 0: out_valid <= 0, and crypte holds its previous value.
- Throughput: one state per cycle. Back-to-back in_valid is fully supported and needs no backpressure.
- Reset:
  - While rst_n = 0, asynchronously force crypte = 128'h0 and out_valid = 0, regardless of clk.
  - After rst_n deasserts, the first capture happens on the first rising edge that has in_valid = 1.
  - If rst_n is asserted mid-stream, any in-flight result is discarded and outputs clear immediately.
- The value of `message` is don't-care when in_valid = 0. X on `message` with in_valid = 0 must not propagate to crypte.
- Required table anchors (hex):
  - 00->52, 01->09, 23->32, 45->68, 52->48, 63->00
  - 67->0a, 89->f2, ab->0e, cd->80, ef->61, ff->7d
- Property: InvSbox(Sbox(x)) = x for all 256 x. The verification engineer checks this against a forward S-box model.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1 and arbitrary `message`, toggling clk → crypte = 0 and out_valid = 0 throughout. Asserting rst_n mid-burst clears both outputs within the same time step, not at the next edge.
- Directed vector:
  - Stimulus: message = 0123456789abcdef0123456789abcdef, in_valid = 1 for one cycle.
  - Next edge: crypte = 0932680af20e80610932680af20e8061 and out_valid = 1.
  - Following edge with in_valid = 0: out_valid = 0 and crypte is unchanged.
- Extremes:
  - message = all 00 → crypte = all 52.
  - message = all ff → crypte = all 7d.
  - message = all 63 → crypte = all 00.
- Byte ordering: message = 00 01 02 ... 0f (byte 0 first) → crypte = 52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb, with byte 0 at bits [0:7].
- Exhaustive / streaming:
  - Drive 16 consecutive cycles with in_valid = 1 so that all 256 byte values appear across the lanes.
  - Each output equals the forward-S-box-inverse model, one cycle later.
  - out_valid stays continuously high.
- Gapped valid: in_valid pattern 1,0,1,1,0 → out_valid pattern delayed by one cycle. crypte updates only after cycles where in_valid was 1.

Source files
------------

// File: rtl/inv_sub_bytes.sv
// AES inverse cipher InvSubBytes stage: 16 parallel inverse S-box lookups,
// registered with a one-cycle valid strobe.
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [0:127] message,
    output logic         out_valid,
    output logic [0:127] crypte
);

    // Entry n of the table is InvSbox(n); element 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    logic [0:127] sub_state;
    logic [0:127] crypte_q, crypte_d;
    logic         valid_q, valid_d;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lane
            assign sub_state[8*gi +: 8] = inv_sbox(message[8*gi +: 8]);
        end
    endgenerate

    // Data is only loaded when qualified, so an undriven message cannot leak out.
    always_comb begin
        crypte_d = crypte_q;
        valid_d  = in_valid;
        if (in_valid) begin
            crypte_d = sub_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crypte_q <= 128'h0;
            valid_q  <= 1'b0;
        end else begin
            crypte_q <= crypte_d;
            valid_q  <= valid_d;
        end
    end

    assign crypte    = crypte_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Scoreboard bench for inv_sub_bytes: the driver queues expected states,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [0:127] message = '0;
    logic         out_valid;
    logic [0:127] crypte;

    int checks = 0;
    int failures = 0;

    logic [0:127] exp_q[$];
    logic [0:127] last_out = '0;
    logic         exp_valid;

    // Forward S-box: the stream test feeds Sbox(v) and expects v back.
    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    inv_sub_bytes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .message   (message),
        .out_valid (out_valid),
        .crypte    (crypte)
    );

    always #5 clk = ~clk;

    // Expected strobe: in_valid delayed one edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_valid <= 1'b0;
        else        exp_valid <= in_valid;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_crypte", crypte, 128'h0);
            check("reset_valid", {127'h0, out_valid}, 128'h0);
            last_out = '0;
        end else begin
            check("out_valid", {127'h0, out_valid}, {127'h0, exp_valid});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h required no output", crypte);
                end else begin
                    check("crypte", crypte, exp_q.pop_front());
                end
                last_out = crypte;
            end else begin
                check("crypte_hold", crypte, last_out);
            end
        end
    end

    task automatic drive(input logic valid, input logic [0:127] msg, input logic [0:127] expv);
        @(posedge clk);
        #1;
        in_valid = valid;
        if (valid) begin
            message = msg;
            exp_q.push_back(expv);
        end else begin
            message = 'x;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish within 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [0:127] m;
        logic [0:127] e;
        logic [7:0]   v;

        // Reset held with live valid input and junk data.
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1;
        message = {$urandom, $urandom, $urandom, $urandom};
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;

        drive(1, 128'h0123456789abcdef0123456789abcdef, 128'h0932680af20e80610932680af20e8061);
        drive(0, '0, '0);
        drive(1, {16{8'h00}}, {16{8'h52}});
        drive(1, {16{8'hff}}, {16{8'h7d}});
        drive(1, {16{8'h63}}, {16{8'h00}});
        drive(1, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
        drive(0, '0, '0);

        // Gapped valid 1,0,1,1,0.
        drive(1, {16{8'h23}}, {16{8'h32}});
        drive(0, '0, '0);
        drive(1, {16{8'h45}}, {16{8'h68}});
        drive(1, {16{8'h52}}, {16{8'h48}});
        drive(0, '0, '0);

        // Stream all 256 values through the lanes, back to back.
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 16; k++) begin
                v = 8'(c * 16 + k);
                m[8*k +: 8] = FWD_SBOX[v];
                e[8*k +: 8] = v;
            end
            drive(1, m, e);
        end
        drive(0, '0, '0);

        // Reset mid-burst: outputs clear in the same time step.
        drive(1, {16{8'h89}}, {16{8'hf2}});
        drive(1, {16{8'hab}}, {16{8'h0e}});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr_crypte", crypte, 128'h0);
        check("async_clr_valid", {127'h0, out_valid}, 128'h0);
        exp_q.delete();
        message = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;

        drive(1, {16{8'hcd}}, {16{8'h80}});
        drive(1, {16{8'hef}}, {16{8'h61}});
        drive(0, '0, '0);
        drive(0, '0, '0);
        @(posedge clk);
        #2;
        check("scoreboard_empty", 128'(exp_q.size()), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
